// File: rtl/rob_walk_ctrl.sv
// rob_walk_ctrl: reorder-buffer bookkeeping plus the flush recovery sequencer.
// Holds the rename result of every dispatched instruction in program order,
// retires up to two entries per cycle onto the commit port and, after a
// flush, replays the surviving uncommitted mappings two per cycle so the
// speculative RAT can be rebuilt from the architectural RAT.
module rob_walk_ctrl #(
  parameter int ROB_DEPTH = 64,
  localparam int IDX_W = $clog2(ROB_DEPTH),
  localparam int PTR_W = IDX_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enq0_valid,
  input  logic             enq1_valid,
  input  logic [4:0]       enq0_lrd,
  input  logic [4:0]       enq1_lrd,
  input  logic [5:0]       enq0_prd,
  input  logic [5:0]       enq1_prd,
  input  logic             enq0_need_to_wb,
  input  logic             enq1_need_to_wb,
  output logic             enq_ready,
  output logic [PTR_W-1:0] enq0_ptr,
  output logic [PTR_W-1:0] enq1_ptr,
  input  logic [1:0]       retire_cnt,
  output logic             commit0_valid,
  output logic             commit1_valid,
  output logic             commit0_need_to_wb,
  output logic             commit1_need_to_wb,
  output logic [4:0]       commit0_lrd,
  output logic [4:0]       commit1_lrd,
  output logic [5:0]       commit0_prd,
  output logic [5:0]       commit1_prd,
  input  logic             flush_valid,
  input  logic [PTR_W-1:0] flush_ptr,
  output logic [1:0]       rob_state,
  output logic             rob_walk0_valid,
  output logic             rob_walk1_valid,
  output logic [4:0]       rob_walk0_lrd,
  output logic [4:0]       rob_walk1_lrd,
  output logic [5:0]       rob_walk0_prd,
  output logic [5:0]       rob_walk1_prd,
  output logic [PTR_W-1:0] rob_count
);

  typedef enum logic [1:0] {
    ROB_STATE_IDLE     = 2'd0,
    ROB_STATE_ROLLBACK = 2'd1,
    ROB_STATE_WALK     = 2'd2
  } rob_state_e;

  rob_state_e state, next_state;

  logic [4:0]           lrd_mem [ROB_DEPTH];
  logic [5:0]           prd_mem [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] wb_mem;

  logic [PTR_W-1:0] head, tail, walk_ptr, walk_end;
  logic [PTR_W-1:0] count;
  logic [PTR_W-1:0] flush_dist;
  logic [PTR_W-1:0] walk_rem;
  logic [IDX_W-1:0] head_idx0, head_idx1, walk_idx0, walk_idx1;
  logic [IDX_W-1:0] tail_idx0, tail_idx1;
  logic [1:0]       retire_req, retire_eff;
  logic [1:0]       walk_step;
  logic             flush_accept;
  logic             enq_fire, enq_two;
  logic             walk_elig0, walk_elig1;

  // Occupancy, pointer indices and the admission decisions for this cycle
  always_comb begin
    count      = tail - head;
    head_idx0  = head[IDX_W-1:0];
    head_idx1  = head_idx0 + 1'b1;
    tail_idx0  = tail[IDX_W-1:0];
    tail_idx1  = tail_idx0 + 1'b1;
    walk_idx0  = walk_ptr[IDX_W-1:0];
    walk_idx1  = walk_idx0 + 1'b1;
    enq_ready  = (count <= PTR_W'(ROB_DEPTH - 2)) && (state == ROB_STATE_IDLE);
    enq0_ptr   = tail;
    enq1_ptr   = tail + 1'b1;
    rob_count  = count;
    rob_state  = state;
    // A keep-pointer is legal from head-1 (keep nothing) up to tail-1 (keep all)
    flush_dist   = flush_ptr - (head - 1'b1);
    flush_accept = (state == ROB_STATE_IDLE) && flush_valid && (flush_dist <= count);
    enq_fire     = enq_ready && enq0_valid && !flush_accept;
    enq_two      = enq_fire && enq1_valid;
    retire_req   = (retire_cnt > 2'd2) ? 2'd2 : retire_cnt;
    retire_eff   = (count < PTR_W'(retire_req)) ? count[1:0] : retire_req;
    walk_rem     = walk_end - walk_ptr;
    walk_elig0   = (state == ROB_STATE_WALK) && (walk_rem != '0);
    walk_elig1   = (state == ROB_STATE_WALK) && (walk_rem >= PTR_W'(2));
    walk_step    = {1'b0, walk_elig0} + {1'b0, walk_elig1};
  end

  // Commit lanes read the oldest entries combinationally; zero when not retiring
  always_comb begin
    commit0_valid      = 1'b0;
    commit1_valid      = 1'b0;
    commit0_need_to_wb = 1'b0;
    commit1_need_to_wb = 1'b0;
    commit0_lrd        = '0;
    commit1_lrd        = '0;
    commit0_prd        = '0;
    commit1_prd        = '0;
    if (retire_eff >= 2'd1) begin
      commit0_valid      = 1'b1;
      commit0_need_to_wb = wb_mem[head_idx0];
      commit0_lrd        = lrd_mem[head_idx0];
      commit0_prd        = prd_mem[head_idx0];
    end
    if (retire_eff == 2'd2) begin
      commit1_valid      = 1'b1;
      commit1_need_to_wb = wb_mem[head_idx1];
      commit1_lrd        = lrd_mem[head_idx1];
      commit1_prd        = prd_mem[head_idx1];
    end
  end

  // Walk lanes replay surviving entries; entries without a destination burn a slot silently
  always_comb begin
    rob_walk0_valid = 1'b0;
    rob_walk1_valid = 1'b0;
    rob_walk0_lrd   = '0;
    rob_walk1_lrd   = '0;
    rob_walk0_prd   = '0;
    rob_walk1_prd   = '0;
    if (walk_elig0) begin
      rob_walk0_valid = wb_mem[walk_idx0];
      rob_walk0_lrd   = lrd_mem[walk_idx0];
      rob_walk0_prd   = prd_mem[walk_idx0];
    end
    if (walk_elig1) begin
      rob_walk1_valid = wb_mem[walk_idx1];
      rob_walk1_lrd   = lrd_mem[walk_idx1];
      rob_walk1_prd   = prd_mem[walk_idx1];
    end
  end

  // Recovery sequencer: IDLE -> ROLLBACK (one cycle) -> WALK until walk_end is reached
  always_comb begin
    next_state = state;
    case (state)
      ROB_STATE_IDLE: begin
        if (flush_accept) next_state = ROB_STATE_ROLLBACK;
      end
      ROB_STATE_ROLLBACK: begin
        next_state = (head != walk_end) ? ROB_STATE_WALK : ROB_STATE_IDLE;
      end
      ROB_STATE_WALK: begin
        if (walk_rem <= PTR_W'(2)) next_state = ROB_STATE_IDLE;
      end
      default: next_state = ROB_STATE_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ROB_STATE_IDLE;
    else       state <= next_state;
  end

  // Pointer updates; walk_ptr captures the pre-retire head so same-cycle commits still replay
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      walk_ptr <= '0;
      walk_end <= '0;
    end else begin
      head <= head + PTR_W'(retire_eff);
      if (flush_accept) begin
        tail     <= flush_ptr + 1'b1;
        walk_end <= flush_ptr + 1'b1;
      end else if (enq_fire) begin
        tail <= tail + (enq_two ? PTR_W'(2) : PTR_W'(1));
      end
      if (state == ROB_STATE_ROLLBACK)  walk_ptr <= head;
      else if (state == ROB_STATE_WALK) walk_ptr <= walk_ptr + PTR_W'(walk_step);
    end
  end

  // Entry storage needs no reset; only slots between head and tail are ever read
  always_ff @(posedge clock) begin
    if (enq_fire) begin
      lrd_mem[tail_idx0] <= enq0_lrd;
      prd_mem[tail_idx0] <= enq0_prd;
      wb_mem[tail_idx0]  <= enq0_need_to_wb;
    end
    if (enq_two) begin
      lrd_mem[tail_idx1] <= enq1_lrd;
      prd_mem[tail_idx1] <= enq1_prd;
      wb_mem[tail_idx1]  <= enq1_need_to_wb;
    end
  end

endmodule
